sample_transmitter: RTL and testbench

Transmit-side responder to the task dispatcher's TXD grant. While `grant_txd` is high, it reads the captured sample buffer from address 0 upward and feeds each byte to the UART transmitter through a start/busy handshake. When the frame is finished it raises `done_txd` so the dispatcher can return to acquisition. It sits between the dispatcher, the sample RAM read port and the UART TX.

---
 rtl/sample_transmitter.sv | 129 ++++++++++++
 tb/tb_sample_transmitter.sv | 275 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/sample_transmitter.sv
// Streams NUM_SAMPLES bytes from sample RAM to the UART while grant_txd is held, then raises done_txd.
// Define SAMPLE_TRANSMITTER_CHECKSUM_EN to append an XOR checksum byte to each frame.
module sample_transmitter #(
    parameter int ADDR_W      = 8,
    parameter int NUM_SAMPLES = 256
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              grant_txd,
    output logic              done_txd,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic [7:0]        mem_data,
    output logic [7:0]        tx_data,
    output logic              tx_start,
    input  logic              tx_busy
);

`ifdef SAMPLE_TRANSMITTER_CHECKSUM_EN
    typedef enum logic [2:0] {IDLE, FETCH, LOAD, START, ACK, DRAIN, CKSUM, DONE} state_t;
`else
    typedef enum logic [2:0] {IDLE, FETCH, LOAD, START, ACK, DRAIN, DONE} state_t;
`endif

    // Count is one bit wider than the address so NUM_SAMPLES = 2^ADDR_W fits.
    localparam logic [ADDR_W:0] LAST = (ADDR_W+1)'(NUM_SAMPLES - 1);

    state_t          state;
    logic [ADDR_W:0] count;
`ifdef SAMPLE_TRANSMITTER_CHECKSUM_EN
    logic [7:0]      cksum;
    logic            cksum_sent;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            done_txd <= 1'b0;
            tx_start <= 1'b0;
            tx_data  <= '0;
            mem_addr <= '0;
            count    <= '0;
`ifdef SAMPLE_TRANSMITTER_CHECKSUM_EN
            cksum      <= '0;
            cksum_sent <= 1'b0;
`endif
        end else begin
            tx_start <= 1'b0;
            // Losing the grant mid-frame abandons it; an issued tx_start is left to the UART.
            if (!grant_txd && state != IDLE && state != DONE) begin
                state    <= IDLE;
                mem_addr <= '0;
                count    <= '0;
            end else begin
                case (state)
                    IDLE: begin
                        mem_addr <= '0;
                        count    <= '0;
                        done_txd <= 1'b0;
`ifdef SAMPLE_TRANSMITTER_CHECKSUM_EN
                        cksum      <= '0;
                        cksum_sent <= 1'b0;
`endif
                        if (grant_txd)
                            state <= FETCH;
                    end
                    FETCH: state <= LOAD;
                    LOAD: begin
                        tx_data  <= mem_data;
                        tx_start <= 1'b1;
`ifdef SAMPLE_TRANSMITTER_CHECKSUM_EN
                        cksum <= cksum ^ mem_data;
`endif
                        state <= START;
                    end
                    START: state <= ACK;
                    ACK: begin
                        if (tx_busy)
                            state <= DRAIN;
                    end
`ifdef SAMPLE_TRANSMITTER_CHECKSUM_EN
                    DRAIN: begin
                        if (!tx_busy) begin
                            if (cksum_sent) begin
                                done_txd <= 1'b1;
                                state    <= DONE;
                            end else if (count == LAST) begin
                                state <= CKSUM;
                            end else begin
                                count    <= count + (ADDR_W+1)'(1);
                                mem_addr <= mem_addr + ADDR_W'(1);
                                state    <= FETCH;
                            end
                        end
                    end
                    CKSUM: begin
                        tx_data    <= cksum;
                        tx_start   <= 1'b1;
                        cksum_sent <= 1'b1;
                        state      <= START;
                    end
`else
                    DRAIN: begin
                        if (!tx_busy) begin
                            if (count == LAST) begin
                                done_txd <= 1'b1;
                                state    <= DONE;
                            end else begin
                                count    <= count + (ADDR_W+1)'(1);
                                mem_addr <= mem_addr + ADDR_W'(1);
                                state    <= FETCH;
                            end
                        end
                    end
`endif
                    DONE: begin
                        if (!grant_txd) begin
                            done_txd <= 1'b0;
                            mem_addr <= '0;
                            count    <= '0;
                            state    <= IDLE;
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_sample_transmitter.sv
// Two transmitters (4 samples on a 2-bit address, and 1 sample) share clk/rst/grant; each is
// checked cycle by cycle against a byte-index/gap-countdown model of the frame protocol.
module tb_sample_transmitter;

    localparam int AW  = 2;
    localparam int NS0 = 4;
    localparam int NS1 = 1;
`ifdef SAMPLE_TRANSMITTER_CHECKSUM_EN
    localparam int XB = 1;
`else
    localparam int XB = 0;
`endif

    logic          clk = 1'b0;
    logic          rst;
    logic          grant_txd;
    logic [1:0]    tx_start_v;
    logic [1:0]    done_v;
    logic [1:0]    busy_v;
    logic [AW-1:0] addr_v  [2];
    logic [7:0]    rdata_v [2];
    logic [7:0]    txd_v   [2];

    always #5 clk = ~clk;

    sample_transmitter #(.ADDR_W(AW), .NUM_SAMPLES(NS0)) dut0 (
        .clk(clk), .rst(rst), .grant_txd(grant_txd), .done_txd(done_v[0]),
        .mem_addr(addr_v[0]), .mem_data(rdata_v[0]), .tx_data(txd_v[0]),
        .tx_start(tx_start_v[0]), .tx_busy(busy_v[0])
    );

    sample_transmitter #(.ADDR_W(AW), .NUM_SAMPLES(NS1)) dut1 (
        .clk(clk), .rst(rst), .grant_txd(grant_txd), .done_txd(done_v[1]),
        .mem_addr(addr_v[1]), .mem_data(rdata_v[1]), .tx_data(txd_v[1]),
        .tx_start(tx_start_v[1]), .tx_busy(busy_v[1])
    );

    typedef enum int {P_IDLE, P_GAP, P_PULSE, P_WAITB, P_WAITF, P_DONE} phase_t;

    phase_t     ph  [2];
    int         idx [2];
    int         gap [2];
    logic [7:0] ram [2][4];
    int         n_checks  = 0;
    int         n_errors  = 0;
    bit         armed     = 1'b0;
    bit         after_rst = 1'b0;
    bit         rand_uart = 1'b0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at t=%0t", tag, got, exp, $time);
        end
    endtask

    function automatic int nsamp(input int g);
        return (g == 0) ? NS0 : NS1;
    endfunction

    // Byte i of the frame: RAM contents in address order, then optionally the XOR of all of them.
    function automatic logic [7:0] frame_byte(input int g, input int i);
        logic [7:0] x;
        x = 8'h00;
        if (i < nsamp(g))
            return ram[g][i];
        for (int j = 0; j < nsamp(g); j++)
            x = x ^ ram[g][j];
        return x;
    endfunction

    // Reference model: update from inputs sampled at the edge, compare outputs mid-cycle.
    initial begin
        logic       r, gr;
        logic [1:0] b;
        int         n, fl, exp_addr;
        ph[0] = P_IDLE; ph[1] = P_IDLE;
        idx[0] = 0; idx[1] = 0; gap[0] = 0; gap[1] = 0;
        forever begin
            @(posedge clk);
            r  = rst;
            gr = grant_txd;
            b  = busy_v;
            for (int g = 0; g < 2; g++) begin
                n  = nsamp(g);
                fl = n + XB;
                if (r) begin
                    ph[g]  = P_IDLE;
                    idx[g] = 0;
                end else if (ph[g] != P_IDLE && ph[g] != P_DONE && !gr) begin
                    ph[g] = P_IDLE;
                end else begin
                    case (ph[g])
                        P_IDLE:  if (gr) begin ph[g] = P_GAP; idx[g] = 0; gap[g] = 2; end
                        P_GAP:   begin gap[g]--; if (gap[g] == 0) ph[g] = P_PULSE; end
                        P_PULSE: ph[g] = P_WAITB;
                        P_WAITB: if (b[g]) ph[g] = P_WAITF;
                        P_WAITF: begin
                            if (!b[g]) begin
                                if (idx[g] == fl - 1) begin
                                    ph[g] = P_DONE;
                                end else begin
                                    idx[g]++;
                                    ph[g]  = P_GAP;
                                    gap[g] = (idx[g] == n) ? 1 : 2;
                                end
                            end
                        end
                        P_DONE:  if (!gr) ph[g] = P_IDLE;
                        default: ph[g] = P_IDLE;
                    endcase
                end
            end
            if (r) armed = 1'b1;
            after_rst = r;
            @(negedge clk);
            if (armed) begin
                for (int g = 0; g < 2; g++) begin
                    n = nsamp(g);
                    exp_addr = (ph[g] == P_IDLE) ? 0 : ((idx[g] < n) ? idx[g] : n - 1);
                    check_eq($sformatf("tx_start[%0d]", g), 32'(tx_start_v[g]), 32'(ph[g] == P_PULSE));
                    check_eq($sformatf("done_txd[%0d]", g), 32'(done_v[g]), 32'(ph[g] == P_DONE));
                    check_eq($sformatf("mem_addr[%0d]", g), 32'(addr_v[g]), 32'(exp_addr));
                    if (ph[g] == P_PULSE)
                        check_eq($sformatf("tx_data[%0d] byte %0d", g, idx[g]), 32'(txd_v[g]),
                                 32'(frame_byte(g, idx[g])));
                    if (after_rst)
                        check_eq($sformatf("tx_data_reset[%0d]", g), 32'(txd_v[g]), 32'h0);
                end
            end
        end
    end

    // RAM with one-cycle read latency and a UART that goes busy 1-2 clks after tx_start.
    initial begin
        int            pend [2];
        int            cnt  [2];
        int            len, d;
        logic          st   [2];
        logic [AW-1:0] a    [2];
        pend = '{0, 0};
        cnt  = '{0, 0};
        busy_v = 2'b00;
        rdata_v[0] = 8'h00;
        rdata_v[1] = 8'h00;
        forever begin
            @(negedge clk);
            for (int g = 0; g < 2; g++) begin
                st[g] = tx_start_v[g];
                a[g]  = addr_v[g];
            end
            @(posedge clk);
            #1;
            for (int g = 0; g < 2; g++) begin
                rdata_v[g] = (a[g] === 'x) ? 8'h00 : ram[g][a[g]];
                if (pend[g] > 0) begin
                    pend[g]--;
                    if (pend[g] == 0) begin
                        busy_v[g] = 1'b1;
                        cnt[g]    = rand_uart ? int'($urandom_range(1, 6)) : 5;
                    end
                end else if (cnt[g] > 0) begin
                    cnt[g]--;
                    if (cnt[g] == 0) busy_v[g] = 1'b0;
                end
                if (st[g] === 1'b1 && !busy_v[g] && pend[g] == 0) begin
                    len = rand_uart ? int'($urandom_range(1, 6)) : 5;
                    d   = rand_uart ? int'($urandom_range(1, 2)) : 1;
                    if (d == 1) begin
                        busy_v[g] = 1'b1;
                        cnt[g]    = len;
                    end else begin
                        pend[g] = 1;
                    end
                end
            end
        end
    end

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic wait_done(input int limit);
        int k;
        k = 0;
        while (!(ph[0] == P_DONE && ph[1] == P_DONE) && k < limit) begin
            @(negedge clk);
            k++;
        end
        check_eq("frame_done_in_time", 32'(ph[0] == P_DONE && ph[1] == P_DONE), 32'd1);
    endtask

    task automatic wait_lane0(input phase_t p, input int i, input int limit);
        int k;
        k = 0;
        while (!(ph[0] == p && idx[0] == i) && k < limit) begin
            @(negedge clk);
            k++;
        end
        check_eq("lane0_reached_phase", 32'(ph[0] == p && idx[0] == i), 32'd1);
    endtask

    initial begin
        rst       = 1'b1;
        grant_txd = 1'b0;
        ram[0][0] = 8'h11; ram[0][1] = 8'h22; ram[0][2] = 8'h33; ram[0][3] = 8'h44;
        ram[1][0] = 8'h5a; ram[1][1] = 8'h00; ram[1][2] = 8'h00; ram[1][3] = 8'h00;

        // Reset, then idle with no grant
        cyc(2);
        rst = 1'b0;
        cyc(20);

        // Full frame, hold done, release grant
        grant_txd = 1'b1;
        wait_done(400);
        cyc(3);
        grant_txd = 1'b0;
        cyc(3);

        // Abort during the second byte's drain, then re-grant
        grant_txd = 1'b1;
        wait_lane0(P_WAITF, 1, 200);
        grant_txd = 1'b0;
        cyc(6);
        grant_txd = 1'b1;
        wait_done(400);
        grant_txd = 1'b0;
        cyc(2);

        // Reset while waiting for busy on the third byte, grant held
        grant_txd = 1'b1;
        wait_lane0(P_WAITB, 2, 200);
        rst = 1'b1;
        cyc(1);
        rst = 1'b0;
        wait_done(400);
        grant_txd = 1'b0;
        cyc(2);

        // Grant rising together with reset
        rst       = 1'b1;
        grant_txd = 1'b1;
        cyc(1);
        rst = 1'b0;
        wait_done(400);
        grant_txd = 1'b0;
        cyc(2);

        // Randomized frames, UART timing and aborts
        rand_uart = 1'b1;
        repeat (30) begin
            for (int g = 0; g < 2; g++)
                for (int i = 0; i < 4; i++)
                    ram[g][i] = 8'($urandom);
            cyc($urandom_range(0, 3));
            grant_txd = 1'b1;
            if ($urandom_range(0, 2) == 0) begin
                cyc($urandom_range(1, 40));
            end else begin
                wait_done(600);
                cyc($urandom_range(0, 3));
            end
            grant_txd = 1'b0;
            cyc($urandom_range(1, 3));
        end

        cyc(3);
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
